// File: rtl/ysyx_2022040010_icache_refill_if.sv
// Memory read bus between the icache refill engine (master) and the core's memory read port (slave).
interface ysyx_2022040010_icache_refill_if;
  logic        rd_req;
  logic [63:0] rd_addr;
  logic [3:0]  rd_len;
  logic        rd_ready;
  logic        rd_valid;
  logic [63:0] rd_data;
  logic        rd_last;

  modport master (
    output rd_req, rd_addr, rd_len,
    input  rd_ready, rd_valid, rd_data, rd_last
  );

  modport slave (
    input  rd_req, rd_addr, rd_len,
    output rd_ready, rd_valid, rd_data, rd_last
  );
endinterface

// File: rtl/ysyx_2022040010_icache_refill.sv
// Icache miss refill engine: fetches one line over the read bus, writes each beat into the
// LRU-chosen way of the data array, then pulses refresh so the tag array installs the tag.
module ysyx_2022040010_icache_refill #(
  parameter int BEATS = 1,
  parameter int OFS_W = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        miss,
  input  logic        flush,
  input  logic [63:0] sram_addr,
  input  logic        lru,
  output logic        busy,
  ysyx_2022040010_icache_refill_if.master bus,
  output logic [1:0]  data_we,
  output logic [5:0]  data_index,
  output logic [2:0]  data_beat,
  output logic [63:0] data_wdata,
  output logic        refresh,
  output logic        err
);

  localparam logic [2:0] LAST_BEAT = 3'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, REQ, RECV, DONE} state_t;

  state_t      state;
  logic [63:0] addr_q;
  logic        way_q;
  logic        drop_q;
  logic [2:0]  cnt;
  logic        beat_fire;
  logic        last_beat;

  function automatic logic [63:0] line_base(input logic [63:0] addr);
    return addr & ~((64'd1 << OFS_W) - 64'd1);
  endfunction

  // Saturating beat counter: stops at the final slot so it never spills into a next line.
  function automatic logic [2:0] sat_inc(input logic [2:0] value);
    return (value == LAST_BEAT) ? value : value + 3'd1;
  endfunction

  assign beat_fire = (state == RECV) & bus.rd_valid;
  assign last_beat = (cnt == LAST_BEAT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      drop_q <= 1'b0;
      cnt    <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (miss & ~flush) begin
            state  <= REQ;
            drop_q <= 1'b0;
            cnt    <= 3'd0;
          end
        end
        REQ: begin
          if (flush) drop_q <= 1'b1;
          if (bus.rd_ready) state <= RECV;
        end
        RECV: begin
          // A flushed line is still drained to keep the bus consistent; only its writes are dropped.
          if (flush) drop_q <= 1'b1;
          if (bus.rd_valid) begin
            if (last_beat) state <= DONE;
            else           cnt   <= sat_inc(cnt);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Target line and way are frozen at miss acceptance; later LRU updates do not move the refill.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && miss && !flush) begin
      addr_q <= sram_addr;
      way_q  <= lru;
    end
  end

  assign busy        = (state != IDLE);
  assign bus.rd_req  = (state == REQ);
  assign bus.rd_addr = (state == REQ) ? line_base(addr_q) : 64'd0;
  assign bus.rd_len  = 4'(BEATS - 1);

  assign data_we    = (beat_fire & ~drop_q) ? (way_q ? 2'b10 : 2'b01) : 2'b00;
  assign data_index = beat_fire ? addr_q[OFS_W+5:OFS_W] : 6'd0;
  assign data_beat  = beat_fire ? cnt : 3'd0;
  assign data_wdata = beat_fire ? bus.rd_data : 64'd0;

  // rd_last is only cross-checked against the beat count; it never ends the transfer.
  assign err     = beat_fire & (last_beat ^ bus.rd_last);
  assign refresh = (state == DONE) & ~drop_q & ~flush;

endmodule

// File: doc/ysyx_2022040010_icache_refill.md
# ysyx_2022040010_icache_refill

Miss-handling refill engine for the instruction cache. It answers the tag array's miss indication by fetching the missing line over the memory read bus and writing each beat into the LRU-selected way of the data array. It then pulses `refresh` back to the tag array so the tag is installed. It sits between the icache tag/data arrays and the core's memory read port, and holds the fetch stage stalled via `busy` until the line is resident.

## Interface

- `BEATS`, 1: 64-bit beats per cache line; legal values 1, 2, 4, 8. The line covers `8*BEATS` bytes.
- `OFS_W`, 3: byte-offset width; must equal `3 + log2(BEATS)`.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `miss`  in  1  tag-array miss (cache & sram_e & no hit & ~flush).
- `flush`  in  1  pipeline flush.
- `sram_addr`  in  64  fetch address; the fetch stage holds it stable while `busy`.
- `lru`  in  1  way to replace for `sram_addr`'s index (0 = way0, 1 = way1).
- `busy`  out  1  refill in progress; OR into fetch stall.
- `rd_req`  out  1  read-request valid.
- `rd_addr`  out  64  line-aligned request address.
- `rd_len`  out  4  beat count minus one (`BEATS-1`).
- `rd_ready`  in  1  request accepted when `rd_req & rd_ready`.
- `rd_valid`  in  1  read-data beat valid (no backpressure; the block always accepts).
- `rd_data`  in  64  beat data.
- `rd_last`  in  1  final beat marker.
- `data_we`  out  2  one-hot data-array write enable, `{way1, way0}`.
- `data_index`  out  6  set index to write.
- `data_beat`  out  3  beat slot within the line.
- `data_wdata`  out  64  beat data to write.
- `refresh`  out  1  one-cycle pulse: install tag for the latched way and index.
- `err`  out  1  one-cycle pulse on an `rd_last` / beat-count mismatch.

## Operation

- FSM states: IDLE, REQ, RECV, DONE.
- **IDLE**
  - On `miss & ~flush`: latch `addr_q <= sram_addr`, `way_q <= lru`, `drop_q <= 0`, `cnt <= 0`, then go to REQ.
  - `miss` while `flush` is high is ignored.
- **REQ**
  - Drive `rd_req=1` and `rd_addr = addr_q` with the low `OFS_W` bits zeroed.
  - `rd_addr` and `rd_len` stay stable until the handshake completes.
  - On `rd_req & rd_ready`, go to RECV.
- **RECV**
  - On each `rd_valid` beat:
    - `data_we[way_q] = ~drop_q`
    - `data_index = addr_q[OFS_W+5:OFS_W]`
    - `data_beat = cnt`
    - `data_wdata = rd_data`
    - `cnt++`
  - The beat where `cnt == BEATS-1` ends the transfer, and the FSM goes to DONE.
  - `err` pulses on that beat if `rd_last == 0`, or on any earlier beat where `rd_last == 1`.
  - Completion is always counted in beats; `rd_last` is only checked, never used to end the transfer.
- **DONE**
  - `refresh = ~drop_q` for exactly one cycle, then go to IDLE.
- **Flush during REQ or RECV**
  - `flush` sets `drop_q`.
  - The bus transaction is never abandoned: the request completes and all beats are drained.
  - No data write and no `refresh` occur for a dropped line.
- **Flush in DONE**
  - Also suppresses `refresh`: `refresh = ~drop_q & ~flush`.
- `busy = (state != IDLE)`.
- `miss` outside IDLE is ignored.

## Timing

- **Reset**
  - State returns to IDLE.
  - `busy`, `rd_req`, `data_we`, `refresh`, `err`, `cnt`, and `drop_q` are 0.
  - `rd_addr`, `data_index`, `data_beat`, and `data_wdata` are 0.
- Reset mid-refill aborts immediately. Beats arriving after reset are ignored (IDLE ignores `rd_valid`).
- **Latency with zero-wait bus**
  - Cycle 0: `miss` sampled.
  - Cycle 1: `rd_req` high.
  - With `rd_ready` in cycle 1 and beats from cycle 2, the last beat lands in cycle `1+BEATS`.
  - `refresh` occurs in cycle `2+BEATS`, with IDLE in the following cycle.
- `busy` rises the cycle after `miss` and falls the cycle after `refresh`.
- **Outputs**
  - `data_*` outputs are combinational from registered state and `rd_*` (same-cycle write).
  - `refresh` and `rd_req` are pure functions of state.
- **Beat counter**
  - The beat counter is 3 bits and saturates at `BEATS-1`; it never wraps into a second line.
  - With `BEATS=1`, RECV lasts exactly one `rd_valid` beat.
- **LRU**
  - `way_q` is frozen at miss acceptance. LRU updates made by the tag array during the refill do not change the target way.

## Test plan

- **Basic refill**: `BEATS=1`, `sram_addr=0x8000_0124`, `lru=1`, zero-wait bus → `rd_addr=0x8000_0120`, one write with `data_we=2'b10`, `index=0x24`, `beat=0`; `refresh` in cycle 3.
- **Burst**: `BEATS=4`, `addr=0x8000_1038`, `lru=0`, `rd_ready` delayed 3 cycles, beats `D0..D3` with 1-cycle gaps → `rd_addr=0x8000_1020`, `rd_len=3`, writes to beats 0..3 of way0 at index 1, exactly one `refresh` after `D3`.
- **Flush mid-RECV**: `flush` pulsed after beat 1 of 4 → remaining beats drained, `data_we=0` from then on, no `refresh`, `busy` drops after beat 3 plus 1 cycle.
- **Protocol error**: `rd_last` on beat 2 of 4 → `err` pulse at beat 2; transfer still ends on beat 3 with `refresh`.
- **Reset mid-REQ**: `rst` while `rd_req=1` → next cycle all outputs 0 and state IDLE; a stray `rd_valid` afterwards produces no write.
- **Miss with flush, and miss while busy**: `miss & flush` in IDLE → no request. A second `miss` asserted during RECV → ignored, a single transaction only.
